// File: rtl/nibble_chain_seq.sv
// Sequences a multi-nibble operation through a 4-bit ALU, low nibble first, chaining carry.
// Latency: start sampled at edge t -> busy t+1..t+NIBBLES, done pulse at t+NIBBLES+1.
// Backpressure: none; start is only honoured in IDLE and is never queued.
module nibble_chain_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic                 bank,
  input  logic                 cin,
  input  logic [4*NIBBLES-1:0] a_word,
  input  logic [4*NIBBLES-1:0] b_word,
  output logic [3:0]           alu_A,
  output logic [3:0]           alu_B,
  output logic [2:0]           alu_op,
  output logic                 alu_bank,
  output logic                 alu_cin,
  input  logic [3:0]           alu_result,
  input  logic [3:0]           alu_flags,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result_word,
  output logic [3:0]           flags_out
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [2:0]      op_q;
  logic            bank_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [IW-1:0]   idx;
  logic            carry;
  logic            zacc;
  logic [W-1:0]    result_q;
  logic [3:0]      flags_q;

  logic            last;
  logic            chained;
  logic            bflags;

  // Arithmetic ops (op 0/1) chain carry in both banks; op 6 in bank 0 passes flags straight through.
  assign last    = (idx == IW'(NIBBLES - 1));
  assign chained = (op_q == 3'd0) || (op_q == 3'd1);
  assign bflags  = !bank_q && (op_q == 3'd6);

  assign alu_op      = op_q;
  assign alu_bank    = bank_q;
  assign result_word = result_q;
  assign flags_out   = flags_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and ALU drive: operands only presented while RUN, zero otherwise.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_A     = 4'd0;
    alu_B     = 4'd0;
    alu_cin   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        alu_A   = a_q[{idx, 2'b00} +: 4];
        alu_B   = b_q[{idx, 2'b00} +: 4];
        alu_cin = chained ? carry : 1'b0;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, per-nibble result capture, carry chain and Z accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= 3'd0;
      bank_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      zacc     <= 1'b1;
      result_q <= '0;
      flags_q  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            bank_q <= bank;
            a_q    <= a_word;
            b_q    <= b_word;
            idx    <= '0;
            carry  <= cin;
            zacc   <= 1'b1;
          end
        end
        RUN: begin
          result_q[{idx, 2'b00} +: 4] <= alu_result;
          carry <= alu_flags[0];
          zacc  <= zacc & alu_flags[2];
          if (last) begin
            idx <= '0;
            if (bflags) begin
              flags_q <= alu_flags;
            end else begin
              flags_q <= {alu_flags[3], zacc & alu_flags[2], alu_flags[1], alu_flags[0]};
            end
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_chain_seq.sv
// Directed bench for nibble_chain_seq with a behavioural 4-bit ALU model in the loop.
// Each scenario task drives one operation and compares against hand-computed values.
// Summary line reports errors and total comparisons.
module tb_nibble_chain_seq;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic          bank;
  logic          cin;
  logic [15:0]   a_word;
  logic [15:0]   b_word;
  logic [3:0]    alu_A;
  logic [3:0]    alu_B;
  logic [2:0]    alu_op;
  logic          alu_bank;
  logic          alu_cin;
  logic [3:0]    alu_result;
  logic [3:0]    alu_flags;
  logic          busy;
  logic          done;
  logic [15:0]   result_word;
  logic [3:0]    flags_out;

  int errors = 0;
  int checks = 0;

  // Captured per-run observations.
  logic [3:0]  busy_seq;
  logic [3:0]  cin_seq;
  logic [15:0] a_seq;
  logic [15:0] b_seq;
  logic        done_mid;
  logic        done_end;
  logic        busy_end;
  logic [3:0]  a_end;
  logic [2:0]  op_end;
  logic        bank_end;
  logic [15:0] res_end;
  logic [3:0]  flg_end;

  nibble_chain_seq #(.NIBBLES(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .bank        (bank),
    .cin         (cin),
    .a_word      (a_word),
    .b_word      (b_word),
    .alu_A       (alu_A),
    .alu_B       (alu_B),
    .alu_op      (alu_op),
    .alu_bank    (alu_bank),
    .alu_cin     (alu_cin),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .busy        (busy),
    .done        (done),
    .result_word (result_word),
    .flags_out   (flags_out)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: ADD/SUB (bank1), DADD/DSUB (bank0), AND, and BFLAGS which reflects B as flags.
  logic [4:0] s;
  logic [3:0] r;
  logic       c;
  logic       v;
  always_comb begin
    s = 5'd0;
    r = 4'd0;
    c = 1'b0;
    v = 1'b0;
    alu_result = 4'd0;
    alu_flags  = 4'd0;
    case ({alu_bank, alu_op})
      4'b1_000: begin
        s = {1'b0, alu_A} + {1'b0, alu_B} + {4'd0, alu_cin};
        r = s[3:0]; c = s[4];
        v = (alu_A[3] == alu_B[3]) && (r[3] != alu_A[3]);
      end
      4'b1_001: begin
        s = {1'b0, alu_A} - {1'b0, alu_B} - {4'd0, alu_cin};
        r = s[3:0]; c = s[4];
        v = (alu_A[3] != alu_B[3]) && (r[3] != alu_A[3]);
      end
      4'b0_000: begin
        s = {1'b0, alu_A} + {1'b0, alu_B} + {4'd0, alu_cin};
        if (s > 5'd9) begin
          s = s + 5'd6;
          c = 1'b1;
        end
        r = s[3:0];
      end
      4'b0_001: begin
        s = {1'b0, alu_A} - {1'b0, alu_B} - {4'd0, alu_cin};
        if (s[4]) begin
          s = s - 5'd6;
          c = 1'b1;
        end
        r = s[3:0];
      end
      4'b0_010: r = alu_A & alu_B;
      4'b0_110: r = alu_A;
      default:  r = 4'd0;
    endcase
    alu_result = r;
    if ({alu_bank, alu_op} == 4'b0_110) alu_flags = alu_B;
    else                                alu_flags = {r[3], (r == 4'd0), v, c};
  end

  // Start one operation from IDLE and record everything through the DONE cycle.
  task automatic run_op(input logic [2:0] o, input logic bk, input logic ci,
                        input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    op = o; bank = bk; cin = ci; a_word = a; b_word = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_mid = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      busy_seq[k]      = busy;
      cin_seq[k]       = alu_cin;
      a_seq[k*4 +: 4]  = alu_A;
      b_seq[k*4 +: 4]  = alu_B;
      if (done) done_mid = 1'b1;
    end
    @(negedge clk);
    done_end = done; busy_end = busy; a_end = alu_A;
    op_end = alu_op; bank_end = alu_bank;
    res_end = result_word; flg_end = flags_out;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'd5; bank = 1'b1; cin = 1'b1;
    a_word = 16'hFFFF; b_word = 16'hFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result_word !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected 0000", result_word); end
    checks++; if (flags_out !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h expected 0", flags_out); end
    checks++;
    if ({alu_A, alu_B, alu_op, alu_bank, alu_cin} !== 13'd0) begin
      errors++; $display("FAIL reset_alu: got %h expected 0000", {alu_A, alu_B, alu_op, alu_bank, alu_cin});
    end
    reset = 1'b0;
  endtask

  task automatic test_add_basic();
    run_op(3'd0, 1'b1, 1'b0, 16'h1234, 16'h0FFF);
    checks++; if (busy_seq !== 4'b1111) begin errors++; $display("FAIL add_busy: got %b expected 1111", busy_seq); end
    checks++; if (done_mid !== 1'b0) begin errors++; $display("FAIL add_early_done: got %b expected 0", done_mid); end
    checks++; if (done_end !== 1'b1 || busy_end !== 1'b0) begin errors++; $display("FAIL add_done_cycle: done %b busy %b expected 1 0", done_end, busy_end); end
    checks++; if (a_seq !== 16'h1234 || b_seq !== 16'h0FFF) begin errors++; $display("FAIL add_nibbles: A %h B %h expected 1234 0fff", a_seq, b_seq); end
    checks++; if (cin_seq !== 4'b1110) begin errors++; $display("FAIL add_cin_seq: got %b expected 1110", cin_seq); end
    checks++; if (res_end !== 16'h2233) begin errors++; $display("FAIL add_result: got %h expected 2233", res_end); end
    checks++; if (flg_end !== 4'b0000) begin errors++; $display("FAIL add_flags: got %b expected 0000", flg_end); end
  endtask

  task automatic test_add_carry();
    run_op(3'd0, 1'b1, 1'b0, 16'hFFFF, 16'h0001);
    checks++; if (cin_seq !== 4'b1110) begin errors++; $display("FAIL addc_cin_seq: got %b expected 1110", cin_seq); end
    checks++; if (res_end !== 16'h0000) begin errors++; $display("FAIL addc_result: got %h expected 0000", res_end); end
    checks++; if (flg_end !== 4'b0101) begin errors++; $display("FAIL addc_flags: got %b expected 0101", flg_end); end
  endtask

  task automatic test_dadd();
    run_op(3'd0, 1'b0, 1'b0, 16'h0999, 16'h0001);
    checks++; if (res_end !== 16'h1000) begin errors++; $display("FAIL dadd_result: got %h expected 1000", res_end); end
    checks++; if (flg_end !== 4'b0000) begin errors++; $display("FAIL dadd_flags: got %b expected 0000", flg_end); end
  endtask

  task automatic test_sub();
    run_op(3'd1, 1'b1, 1'b0, 16'h1000, 16'h0001);
    checks++; if (cin_seq !== 4'b1110) begin errors++; $display("FAIL sub_borrow_seq: got %b expected 1110", cin_seq); end
    checks++; if (res_end !== 16'h0FFF) begin errors++; $display("FAIL sub_result: got %h expected 0fff", res_end); end
    checks++; if (flg_end !== 4'b0000) begin errors++; $display("FAIL sub_flags: got %b expected 0000", flg_end); end
  endtask

  task automatic test_and_unchained();
    run_op(3'd2, 1'b0, 1'b1, 16'hF0F0, 16'h3C3C);
    checks++; if (cin_seq !== 4'b0000) begin errors++; $display("FAIL and_cin_seq: got %b expected 0000", cin_seq); end
    checks++; if (res_end !== 16'h3030) begin errors++; $display("FAIL and_result: got %h expected 3030", res_end); end
    checks++; if (flg_end !== 4'b0000) begin errors++; $display("FAIL and_flags: got %b expected 0000", flg_end); end
    checks++;
    if (a_end !== 4'd0 || op_end !== 3'd2 || bank_end !== 1'b0) begin
      errors++; $display("FAIL and_done_alu: A %h op %0d bank %b expected 0 2 0", a_end, op_end, bank_end);
    end
  endtask

  task automatic test_zero_accum();
    // Top nibble is zero but lower nibble is not: Z must stay clear.
    run_op(3'd0, 1'b1, 1'b0, 16'h0005, 16'h0000);
    checks++; if (res_end !== 16'h0005) begin errors++; $display("FAIL zacc_result: got %h expected 0005", res_end); end
    checks++; if (flg_end !== 4'b0000) begin errors++; $display("FAIL zacc_flags: got %b expected 0000", flg_end); end
  endtask

  task automatic test_bflags();
    run_op(3'd6, 1'b0, 1'b0, 16'h1234, 16'h4000);
    checks++; if (res_end !== 16'h1234) begin errors++; $display("FAIL bflags_result: got %h expected 1234", res_end); end
    checks++; if (flg_end !== 4'b0100) begin errors++; $display("FAIL bflags_flags: got %b expected 0100", flg_end); end
  endtask

  task automatic test_back_to_back_and_abort();
    logic [7:0] busy_h;
    logic [7:0] done_h;
    logic       late_activity;
    busy_h = 8'd0;
    done_h = 8'd0;
    @(negedge clk);
    op = 3'd0; bank = 1'b1; cin = 1'b0; a_word = 16'h1111; b_word = 16'h1111; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      busy_h[k] = busy;
      done_h[k] = done;
    end
    checks++; if (busy_h !== 8'b1001_1110) begin errors++; $display("FAIL hold_busy: got %b expected 10011110", busy_h); end
    checks++; if (done_h !== 8'b0010_0000) begin errors++; $display("FAIL hold_done: got %b expected 00100000", done_h); end
    // Cycle 7 is the first RUN cycle of the second op; abort during its second RUN cycle.
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_state: busy %b done %b expected 0 0", busy, done); end
    checks++; if (result_word !== 16'h0000 || flags_out !== 4'h0) begin errors++; $display("FAIL abort_outputs: result %h flags %h expected 0000 0", result_word, flags_out); end
    checks++;
    if ({alu_A, alu_B, alu_op, alu_bank, alu_cin} !== 13'd0) begin
      errors++; $display("FAIL abort_alu: got %h expected 0000", {alu_A, alu_B, alu_op, alu_bank, alu_cin});
    end
    late_activity = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) late_activity = 1'b1;
    end
    checks++; if (late_activity !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", late_activity); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; bank = 1'b0; cin = 1'b0;
    a_word = 16'h0; b_word = 16'h0;
    test_reset();
    test_add_basic();
    test_add_carry();
    test_dadd();
    test_sub();
    test_and_unchained();
    test_zero_accum();
    test_bflags();
    test_back_to_back_and_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
